// File: rtl/conteo_minas.sv
// Minesweeper neighbour counter: scans a latched 8x8 mine map in row-major order and
// streams one beat per cell. Define CONTEO_SALTAR_MINAS_EN to suppress beats for mine cells.
module conteo_minas (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] mapa_minas,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [2:0]  out_fila,
    output logic [2:0]  out_col,
    output logic [3:0]  out_cuenta,
    output logic        out_mina,
    output logic        busy,
    output logic        done
);

    localparam int unsigned LADO       = 8;
    localparam int unsigned NUM_CELDAS = LADO * LADO;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned COORD_W    = 3;
    localparam int unsigned CUENTA_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [NUM_CELDAS-1:0]   mapa_q, mapa_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    // Set once the output register holds cell idx_q (either a real beat or a skip slot)
    logic                    cargado_q, cargado_d;
    logic                    out_valid_q, out_valid_d;
    logic [COORD_W-1:0]      out_fila_q, out_fila_d;
    logic [COORD_W-1:0]      out_col_q, out_col_d;
    logic [CUENTA_W-1:0]     out_cuenta_q, out_cuenta_d;
    logic                    out_mina_q, out_mina_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    cargar;
    logic [IDX_W-1:0]        idx_carga;

    // Mines in the in-bounds 8-neighbourhood of cell idx, excluding the cell itself
    function automatic logic [CUENTA_W-1:0] contar_vecinos(
        input logic [NUM_CELDAS-1:0] mapa,
        input logic [IDX_W-1:0]      idx
    );
        logic [CUENTA_W-1:0] n;
        logic [IDX_W-1:0]    pos;
        int                  fila;
        int                  col;
        int                  f;
        int                  c;
        n    = '0;
        pos  = '0;
        fila = int'(idx[5:3]);
        col  = int'(idx[2:0]);
        for (int df = -1; df <= 1; df++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                f = fila + df;
                c = col + dc;
                if ((df != 0 || dc != 0) && f >= 0 && f < int'(LADO) && c >= 0 && c < int'(LADO)) begin
                    pos = IDX_W'(f * int'(LADO) + c);
                    n   = n + CUENTA_W'(mapa[pos]);
                end
            end
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= IDLE;
            mapa_q       <= '0;
            idx_q        <= '0;
            cargado_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_fila_q   <= '0;
            out_col_q    <= '0;
            out_cuenta_q <= '0;
            out_mina_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            mapa_q       <= mapa_d;
            idx_q        <= idx_d;
            cargado_q    <= cargado_d;
            out_valid_q  <= out_valid_d;
            out_fila_q   <= out_fila_d;
            out_col_q    <= out_col_d;
            out_cuenta_q <= out_cuenta_d;
            out_mina_q   <= out_mina_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        mapa_d       = mapa_q;
        idx_d        = idx_q;
        cargado_d    = cargado_q;
        out_valid_d  = out_valid_q;
        out_fila_d   = out_fila_q;
        out_col_d    = out_col_q;
        out_cuenta_d = out_cuenta_q;
        out_mina_d   = out_mina_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cargar       = 1'b0;
        idx_carga    = idx_q;

        case (estado_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    mapa_d      = mapa_minas;
                    idx_d       = '0;
                    cargado_d   = 1'b0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    estado_d    = SCAN;
                end
            end
            SCAN: begin
                if (!cargado_q) begin
                    cargar    = 1'b1;
                    idx_carga = idx_q;
                end else if (!out_valid_q || out_ready) begin
                    // Current slot retires: either accepted beat or a skipped mine cell
                    if (idx_q == IDX_W'(NUM_CELDAS - 1)) begin
                        out_valid_d = 1'b0;
                        cargado_d   = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        estado_d    = FIN;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        cargar    = 1'b1;
                        idx_carga = idx_q + IDX_W'(1);
                    end
                end
            end
            FIN: begin
                busy_d   = 1'b0;
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase

        if (cargar) begin
            cargado_d    = 1'b1;
            out_fila_d   = idx_carga[5:3];
            out_col_d    = idx_carga[2:0];
            out_cuenta_d = contar_vecinos(mapa_q, idx_carga);
            out_mina_d   = mapa_q[idx_carga];
`ifdef CONTEO_SALTAR_MINAS_EN
            out_valid_d  = !mapa_q[idx_carga];
`else
            out_valid_d  = 1'b1;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_fila   = out_fila_q;
    assign out_col    = out_col_q;
    assign out_cuenta = out_cuenta_q;
    assign out_mina   = out_mina_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conteo_minas.sv
// Self-checking bench for conteo_minas: constant vector table, randomized scans against
// a padded-grid reference model, backpressure and reset-abort sequences.
module tb_conteo_minas;

    typedef struct packed {
        logic [2:0] fila;
        logic [2:0] col;
        logic [3:0] cuenta;
        logic       mina;
    } beat_t;

    typedef struct {
        logic [63:0] mapa;
        logic [2:0]  fila;
        logic [2:0]  col;
        logic [3:0]  cuenta;
        logic        mina;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] mapa_minas;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_fila;
    logic [2:0]  out_col;
    logic [3:0]  out_cuenta;
    logic        out_mina;
    logic        busy;
    logic        done;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t cap_q[$];
    vec_t  tabla[16];

    always #5 clk = ~clk;

    conteo_minas dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mapa_minas (mapa_minas),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_fila   (out_fila),
        .out_col    (out_col),
        .out_cuenta (out_cuenta),
        .out_mina   (out_mina),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: pad the board with a zero border and sum the 3x3 window minus the centre
    function automatic logic [3:0] model_cuenta(input logic [63:0] m, input int f, input int c);
        int g[10][10];
        int s;
        for (int r = 0; r < 10; r++)
            for (int q = 0; q < 10; q++)
                g[r][q] = 0;
        for (int r = 0; r < 8; r++)
            for (int q = 0; q < 8; q++)
                g[r+1][q+1] = m[6'(r*8 + q)] ? 1 : 0;
        s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dq = 0; dq < 3; dq++)
                s += g[f+dr][c+dq];
        s -= g[f+1][c+1];
        return 4'(s);
    endfunction

    task automatic build_exp(input logic [63:0] m);
        beat_t b;
        exp_q.delete();
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                b.fila   = 3'(f);
                b.col    = 3'(c);
                b.cuenta = model_cuenta(m, f, c);
                b.mina   = m[6'(f*8 + c)];
`ifdef CONTEO_SALTAR_MINAS_EN
                if (b.mina) continue;
`endif
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic compare_beats();
        int n;
        chk("beat_count", 64'(cap_q.size()), 64'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("beat_%0d", i), 64'(cap_q[i]), 64'(exp_q[i]));
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles on cell (2,3)
    task automatic run_scan(input logic [63:0] m, input int mode);
        int    k;
        int    stall;
        bit    fin;
        bit    prev_hold;
        bit    want24;
        logic  rdy;
        beat_t cur;
        beat_t prev;
        build_exp(m);
        cap_q.delete();
        mapa_minas = m;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; stall = 0; fin = 0; prev_hold = 0; want24 = 0;
        prev = '0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("valid_latency", 64'(out_valid), 64'(0));
        while (!fin && k < 400) begin
            cur = {out_fila, out_col, out_cuenta, out_mina};
            if (prev_hold) begin
                chk("hold_beat", 64'(cur), 64'(prev));
                chk("hold_valid", 64'(out_valid), 64'(1));
            end
            if (want24) begin
                chk("bp_next_cell", 64'({out_valid, out_fila, out_col}), 64'({1'b1, 3'd2, 3'd4}));
                want24 = 0;
            end
            if (done) begin
                fin = 1;
                chk("busy_at_done", 64'(busy), 64'(0));
                chk("valid_at_done", 64'(out_valid), 64'(0));
                if (mode == 0) chk("done_latency", 64'(k), 64'(65));
            end else begin
                if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
                else if (mode == 2 && out_valid && out_fila == 3'd2 && out_col == 3'd3 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else rdy = 1'b1;
                if (mode == 2 && out_valid && rdy && out_fila == 3'd2 && out_col == 3'd3) want24 = 1;
                out_ready = rdy;
                if (out_valid && rdy) cap_q.push_back(cur);
                prev_hold = out_valid && !rdy;
                prev = cur;
                @(posedge clk); #1;
                k++;
            end
        end
        chk("scan_done_seen", 64'(fin), 64'(1));
        if (mode == 2) chk("bp_stall_cycles", 64'(stall), 64'(5));
        @(posedge clk); #1;
        chk("done_pulse_width", 64'(done), 64'(0));
        compare_beats();
    endtask

    task automatic reset_abort();
        logic [63:0] ma;
        logic [63:0] mb;
        int          k;
        int          n_pref;
        int          n_done;
        int          n_busy;
        bit          hit;
        ma = {$urandom, $urandom} & ~(64'h1 << 32);
        mb = ~ma;
        build_exp(ma);
        cap_q.delete();
        mapa_minas = ma;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; hit = 0;
        while (!hit && k < 200) begin
            start = (k == 5);
            if (k == 5) mapa_minas = mb;
            if (out_valid && out_fila == 3'd4 && out_col == 3'd0) hit = 1;
            else begin
                if (out_valid) cap_q.push_back({out_fila, out_col, out_cuenta, out_mina});
                @(posedge clk); #1;
                k++;
            end
        end
        chk("reached_cell_4_0", 64'(hit), 64'(1));
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_fields", 64'({out_fila, out_col, out_cuenta, out_mina}), 64'(0));
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 70; i++) begin
            if (done) n_done++;
            if (busy || out_valid) n_busy++;
            @(posedge clk); #1;
        end
        chk("no_done_after_abort", 64'(n_done), 64'(0));
        chk("idle_after_abort", 64'(n_busy), 64'(0));
        n_pref = 0;
        foreach (exp_q[i]) if (exp_q[i].fila < 3'd4) n_pref++;
        chk("prefix_count", 64'(cap_q.size()), 64'(n_pref));
        for (int i = 0; i < cap_q.size() && i < n_pref; i++)
            chk($sformatf("prefix_beat_%0d", i), 64'(cap_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b0;
        mapa_minas = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({out_valid, out_fila, out_col, out_cuenta, out_mina, busy, done}), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        tabla[0]  = '{64'h1, 3'd0, 3'd0, 4'd0, 1'b1};
        tabla[1]  = '{64'h1, 3'd0, 3'd1, 4'd1, 1'b0};
        tabla[2]  = '{64'h1, 3'd1, 3'd0, 4'd1, 1'b0};
        tabla[3]  = '{64'h1, 3'd1, 3'd1, 4'd1, 1'b0};
        tabla[4]  = '{64'h1, 3'd0, 3'd2, 4'd0, 1'b0};
        tabla[5]  = '{64'h1, 3'd7, 3'd7, 4'd0, 1'b0};
        tabla[6]  = '{'1, 3'd0, 3'd0, 4'd3, 1'b1};
        tabla[7]  = '{'1, 3'd7, 3'd7, 4'd3, 1'b1};
        tabla[8]  = '{'1, 3'd0, 3'd3, 4'd5, 1'b1};
        tabla[9]  = '{'1, 3'd4, 3'd0, 4'd5, 1'b1};
        tabla[10] = '{'1, 3'd3, 3'd4, 4'd8, 1'b1};
        tabla[11] = '{'1, 3'd7, 3'd5, 4'd5, 1'b1};
        tabla[12] = '{64'h8000_0000_0800_0000, 3'd3, 3'd3, 4'd0, 1'b1};
        tabla[13] = '{64'h8000_0000_0800_0000, 3'd2, 3'd2, 4'd1, 1'b0};
        tabla[14] = '{64'h8000_0000_0800_0000, 3'd7, 3'd6, 4'd1, 1'b0};
        tabla[15] = '{64'h0, 3'd3, 3'd3, 4'd0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            bit    found;
            beat_t hitb;
            run_scan(tabla[i].mapa, 0);
            found = 0;
            hitb  = '0;
            foreach (cap_q[j])
                if (cap_q[j].fila == tabla[i].fila && cap_q[j].col == tabla[i].col) begin
                    found = 1;
                    hitb  = cap_q[j];
                end
`ifdef CONTEO_SALTAR_MINAS_EN
            if (tabla[i].mina) begin
                chk($sformatf("vec%0d_skipped", i), 64'(found), 64'(0));
                continue;
            end
`endif
            chk($sformatf("vec%0d_found", i), 64'(found), 64'(1));
            chk($sformatf("vec%0d_cuenta", i), 64'(hitb.cuenta), 64'(tabla[i].cuenta));
            chk($sformatf("vec%0d_mina", i), 64'(hitb.mina), 64'(tabla[i].mina));
        end

        for (int i = 0; i < 6; i++) begin
            logic [63:0] m;
            m = {$urandom, $urandom};
            if (i >= 3) m = m & {$urandom, $urandom};
            run_scan(m, 1);
        end

        run_scan({$urandom, $urandom} & ~(64'h3 << 19), 2);
        reset_abort();
        run_scan({$urandom, $urandom}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
